// File: rtl/insert_sha_pkg.sv
// Shared types and width defaults for the transmit-side digest insertion stage.
package insert_sha_pkg;

    localparam int DATA_W_DEF   = 512;
    localparam int KEEP_W_DEF   = 64;
    localparam int ID_W_DEF     = 6;
    localparam int DIGEST_W_DEF = 256;
    localparam int CNT_W_DEF    = 32;
    localparam int MAX_KEEP_W   = 256;

    typedef enum logic [1:0] {
        PASS        = 2'd0,
        WAIT_DIGEST = 2'd1,
        EMIT_LAST   = 2'd2
    } state_t;

    // Byte-enable mask with the low nbytes bits set.
    function automatic logic [MAX_KEEP_W-1:0] low_mask(input int nbytes);
        logic [MAX_KEEP_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < nbytes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/insert_sha_digest_slot.sv
// One-entry digest holding register; filled by the SHA engine, emptied when the digest beat leaves.
module insert_sha_digest_slot #(
    parameter int DIGEST_W = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [DIGEST_W-1:0] load_data,
    input  logic                consume,
    output logic                full,
    output logic [DIGEST_W-1:0] data
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (consume) begin
                full <= 1'b0;
            end else if (load) begin
                full <= 1'b1;
            end
            if (load) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/insert_sha.sv
// Forwards a packet stream and swaps each packet's dummy final beat for its SHA digest.
//
//   state       | meaning
//   ------------+--------------------------------------------------------------
//   PASS        | payload beats forwarded combinationally; final beat absorbed
//   WAIT_DIGEST | final beat absorbed, digest slot still empty
//   EMIT_LAST   | digest beat presented downstream, held until accepted
module insert_sha
    import insert_sha_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int KEEP_W   = KEEP_W_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int DIGEST_W = DIGEST_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                inp_valid,
    output logic                inp_ready,
    input  logic [DATA_W-1:0]   inp_data,
    input  logic [KEEP_W-1:0]   inp_keep,
    input  logic [ID_W-1:0]     inp_id,
    input  logic                inp_last,
    input  logic                digest_valid,
    output logic                digest_ready,
    input  logic [DIGEST_W-1:0] digest_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [KEEP_W-1:0]   out_keep,
    output logic [ID_W-1:0]     out_id,
    output logic                out_last,
    output logic [CNT_W-1:0]    pkt_count
);

    localparam logic [MAX_KEEP_W-1:0] DIGEST_KEEP_FULL = low_mask(DIGEST_W / 8);
    localparam logic [KEEP_W-1:0]     DIGEST_KEEP      = DIGEST_KEEP_FULL[KEEP_W-1:0];

    state_t              state_q, state_d;
    logic [ID_W-1:0]     held_id_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                dig_full;
    logic [DIGEST_W-1:0] dig_data;
    logic                dig_capture;
    logic                dig_consume;
    logic                held_load;

    logic                inp_ready_c;
    logic                out_valid_c;
    logic [DATA_W-1:0]   out_data_c;
    logic [KEEP_W-1:0]   out_keep_c;
    logic [ID_W-1:0]     out_id_c;
    logic                out_last_c;

    // Internal capture ignores reset: the slot flops are held clear while reset is low anyway.
    assign dig_capture = digest_valid && !dig_full;

    insert_sha_digest_slot #(
        .DIGEST_W (DIGEST_W)
    ) u_slot (
        .clock     (clock),
        .reset     (reset),
        .load      (dig_capture),
        .load_data (digest_data),
        .consume   (dig_consume),
        .full      (dig_full),
        .data      (dig_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= PASS;
            held_id_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (held_load) begin
                held_id_q <= inp_id;
            end
            if (dig_consume) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        inp_ready_c = 1'b0;
        out_valid_c = 1'b0;
        out_data_c  = '0;
        out_keep_c  = '0;
        out_id_c    = '0;
        out_last_c  = 1'b0;
        dig_consume = 1'b0;
        held_load   = 1'b0;
        case (state_q)
            PASS: begin
                if (inp_valid) begin
                    if (!inp_last) begin
                        out_valid_c = 1'b1;
                        out_data_c  = inp_data;
                        out_keep_c  = inp_keep;
                        out_id_c    = inp_id;
                        inp_ready_c = out_ready;
                    end else begin
                        inp_ready_c = 1'b1;
                        held_load   = 1'b1;
                        state_d     = (dig_full || dig_capture) ? EMIT_LAST : WAIT_DIGEST;
                    end
                end
            end
            WAIT_DIGEST: begin
                if (dig_full) begin
                    state_d = EMIT_LAST;
                end
            end
            EMIT_LAST: begin
                out_valid_c = 1'b1;
                out_last_c  = 1'b1;
                out_id_c    = held_id_q;
                out_data_c  = DATA_W'(dig_data);
                out_keep_c  = DIGEST_KEEP;
                if (out_ready) begin
                    dig_consume = 1'b1;
                    state_d     = PASS;
                end
            end
            default: begin
                state_d = PASS;
            end
        endcase
    end

    // Handshake outputs drop the moment reset asserts, independent of the clock.
    assign inp_ready    = reset & inp_ready_c;
    assign digest_ready = reset & !dig_full;
    assign out_valid    = reset & out_valid_c;
    assign out_data     = reset ? out_data_c : '0;
    assign out_keep     = reset ? out_keep_c : '0;
    assign out_id       = reset ? out_id_c : '0;
    assign out_last     = reset & out_last_c;
    assign pkt_count    = cnt_q;

endmodule

// File: tb/tb_insert_sha.sv
// Directed scenarios followed by randomized packets checked against a queue-based stream model.
module tb_insert_sha;

    localparam logic [63:0] EXP_KEEP = 64'h0000_0000_FFFF_FFFF;
    localparam int          NPK      = 25;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [5:0]   id;
        logic         last;
    } beat_t;

    logic         clock;
    logic         reset;
    logic         inp_valid;
    logic         inp_ready;
    logic [511:0] inp_data;
    logic [63:0]  inp_keep;
    logic [5:0]   inp_id;
    logic         inp_last;
    logic         digest_valid;
    logic         digest_ready;
    logic [255:0] digest_data;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_data;
    logic [63:0]  out_keep;
    logic [5:0]   out_id;
    logic         out_last;
    logic [31:0]  pkt_count;

    int checks = 0;
    int errors = 0;

    insert_sha dut (
        .clock        (clock),
        .reset        (reset),
        .inp_valid    (inp_valid),
        .inp_ready    (inp_ready),
        .inp_data     (inp_data),
        .inp_keep     (inp_keep),
        .inp_id       (inp_id),
        .inp_last     (inp_last),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest_data  (digest_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_keep     (out_keep),
        .out_id       (out_id),
        .out_last     (out_last),
        .pkt_count    (pkt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic put_beat(input logic [511:0] d, input logic [5:0] id, input logic last);
        inp_valid = 1'b1;
        inp_data  = d;
        inp_keep  = 64'($urandom()) | 64'(1);
        inp_id    = id;
        inp_last  = last;
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic logic [511:0] dext(input logic [255:0] d);
        return {256'h0, d};
    endfunction

    beat_t        in_q[$];
    beat_t        exp_q[$];
    logic [255:0] dg_q[$];

    initial begin
        logic [511:0] d0, d1, d2;
        logic [255:0] da, db;
        beat_t        b, e;
        logic         in_act, dg_act, in_hs, dg_hs;
        int           cycles;

        reset = 1'b0;
        inp_valid = 1'b1; inp_data = rand512(); inp_keep = '1; inp_id = 6'd3; inp_last = 1'b0;
        digest_valid = 1'b1; digest_data = rand256(); out_ready = 1'b1;
        #3;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_inp_ready", inp_ready, 1'b0);
        chk1("rst_digest_ready", digest_ready, 1'b0);
        chkw("rst_out_data", out_data, '0);
        chkw("rst_pkt_count", 512'(pkt_count), '0);
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
        inp_valid = 1'b0; digest_valid = 1'b0;

        // Preloaded digest, 3-beat packet id 5
        da = {8{32'hA5A5_A5A5}};
        cyc(); digest_valid = 1'b1; digest_data = da; #2;
        chk1("t1_dig_ready", digest_ready, 1'b1);
        cyc(); digest_valid = 1'b0; #2;
        chk1("t1_slot_full", digest_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(); d0 = rand512(); put_beat(d0, 6'd5, i == 2); #2;
            if (i < 2) begin
                chk1("t1_fwd_valid", out_valid, 1'b1);
                chkw("t1_fwd_data", out_data, d0);
                chk1("t1_fwd_last", out_last, 1'b0);
            end else begin
                chk1("t1_ph_hidden", out_valid, 1'b0);
            end
            chk1("t1_inp_ready", inp_ready, 1'b1);
        end
        cyc(); inp_valid = 1'b0; #2;
        chk1("t1_dig_valid", out_valid, 1'b1);
        chk1("t1_dig_last", out_last, 1'b1);
        chkw("t1_dig_data", out_data, dext(da));
        chkw("t1_dig_keep", 512'(out_keep), 512'(EXP_KEEP));
        chkw("t1_dig_id", 512'(out_id), 512'(5));
        chk1("t1_emit_inp_ready", inp_ready, 1'b0);
        cyc(); #2;
        chk1("t1_after_valid", out_valid, 1'b0);
        chkw("t1_pkt_count", 512'(pkt_count), 512'(1));
        chk1("t1_slot_free", digest_ready, 1'b1);

        // Late digest, then stalled digest beat
        cyc(); d0 = rand512(); put_beat(d0, 6'd7, 1'b0); #2;
        chkw("t2_fwd_data", out_data, d0);
        cyc(); put_beat(rand512(), 6'd7, 1'b1); #2;
        chk1("t2_ph_ready", inp_ready, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cyc(); put_beat(rand512(), 6'd8, 1'b0); #2;
            chk1("t2_wait_out_valid", out_valid, 1'b0);
            chk1("t2_wait_inp_ready", inp_ready, 1'b0);
        end
        db = rand256();
        cyc(); inp_valid = 1'b0; digest_valid = 1'b1; digest_data = db; #2;
        chk1("t2_dig_ready", digest_ready, 1'b1);
        cyc(); digest_valid = 1'b0; out_ready = 1'b0; #2;
        chk1("t2_capture_cycle", out_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); #2;
            chk1("t3_hold_valid", out_valid, 1'b1);
            chkw("t3_hold_data", out_data, dext(db));
            chkw("t3_hold_id", 512'(out_id), 512'(7));
            chk1("t3_hold_dig_ready", digest_ready, 1'b0);
        end
        cyc(); out_ready = 1'b1; #2;
        chk1("t3_accept_valid", out_valid, 1'b1);
        chk1("t3_accept_dig_ready", digest_ready, 1'b0);
        cyc(); #2;
        chk1("t3_dig_ready_rise", digest_ready, 1'b1);
        chk1("t3_after_valid", out_valid, 1'b0);
        chkw("t3_pkt_count", 512'(pkt_count), 512'(2));

        // Single-beat packet: only the digest leaves
        da = rand256();
        cyc(); digest_valid = 1'b1; digest_data = da;
        cyc(); digest_valid = 1'b0; put_beat({512{1'b1}}, 6'd3, 1'b1); #2;
        chk1("t4_ph_hidden", out_valid, 1'b0);
        chkw("t4_ph_no_leak", out_data, '0);
        chk1("t4_ph_ready", inp_ready, 1'b1);
        cyc(); inp_valid = 1'b0; #2;
        chkw("t4_dig_data", out_data, dext(da));
        chk1("t4_dig_last", out_last, 1'b1);
        cyc(); #2;
        chk1("t4_one_beat", out_valid, 1'b0);
        chkw("t4_pkt_count", 512'(pkt_count), 512'(3));

        // Back-to-back packets with the second digest offered early
        da = rand256(); db = rand256(); d1 = rand512(); d2 = rand512();
        cyc(); digest_valid = 1'b1; digest_data = da;
        cyc(); digest_data = db; put_beat(d1, 6'd1, 1'b0); #2;
        chkw("t5_p1_data", out_data, d1);
        chk1("t5_early_blocked", digest_ready, 1'b0);
        cyc(); put_beat(rand512(), 6'd1, 1'b1); #2;
        chk1("t5_p1_ph_ready", inp_ready, 1'b1);
        cyc(); put_beat(d2, 6'd2, 1'b0); #2;
        chkw("t5_p1_dig_id", 512'(out_id), 512'(1));
        chkw("t5_p1_dig_data", out_data, dext(da));
        chk1("t5_p2_stalled", inp_ready, 1'b0);
        chk1("t5_dig2_blocked", digest_ready, 1'b0);
        cyc(); #2;
        chkw("t5_p2_data", out_data, d2);
        chk1("t5_p2_ready", inp_ready, 1'b1);
        chk1("t5_dig2_ready", digest_ready, 1'b1);
        cyc(); digest_valid = 1'b0; put_beat(rand512(), 6'd2, 1'b1); #2;
        chk1("t5_dig2_captured", digest_ready, 1'b0);
        chk1("t5_p2_ph_hidden", out_valid, 1'b0);
        cyc(); inp_valid = 1'b0; #2;
        chkw("t5_p2_dig_id", 512'(out_id), 512'(2));
        chkw("t5_p2_dig_data", out_data, dext(db));
        cyc(); #2;
        chkw("t5_pkt_count", 512'(pkt_count), 512'(5));

        // Asynchronous reset while emitting
        cyc(); digest_valid = 1'b1; digest_data = rand256();
        cyc(); digest_valid = 1'b0; put_beat(rand512(), 6'd9, 1'b1);
        cyc(); inp_valid = 1'b0; #2;
        chk1("t6_emitting", out_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("t6_rst_out_valid", out_valid, 1'b0);
        chk1("t6_rst_inp_ready", inp_ready, 1'b0);
        chk1("t6_rst_dig_ready", digest_ready, 1'b0);
        chkw("t6_rst_pkt_count", 512'(pkt_count), '0);
        cyc(); #2 reset = 1'b1; #1;
        chk1("t6_no_partial", out_valid, 1'b0);
        chk1("t6_slot_empty", digest_ready, 1'b1);
        da = rand256(); d1 = rand512();
        cyc(); digest_valid = 1'b1; digest_data = da; put_beat(d1, 6'd11, 1'b0); #2;
        chkw("t6_fresh_data", out_data, d1);
        cyc(); digest_valid = 1'b0; put_beat(rand512(), 6'd11, 1'b1); #2;
        chk1("t6_fresh_ph_ready", inp_ready, 1'b1);
        cyc(); inp_valid = 1'b0; #2;
        chkw("t6_fresh_dig", out_data, dext(da));
        chkw("t6_fresh_id", 512'(out_id), 512'(11));
        cyc(); #2;
        chkw("t6_pkt_count", 512'(pkt_count), 512'(1));

        // Random packets against the stream model: payload beats pass, final beat becomes digest
        for (int p = 0; p < NPK; p++) begin
            int len;
            logic [5:0] id;
            logic [255:0] dg;
            len = $urandom_range(1, 4);
            id  = 6'($urandom());
            dg  = rand256();
            dg_q.push_back(dg);
            for (int k = 0; k < len; k++) begin
                b.data = rand512(); b.keep = 64'($urandom()); b.id = id; b.last = (k == len - 1);
                in_q.push_back(b);
                if (!b.last) exp_q.push_back(b);
                else begin
                    e.data = dext(dg); e.keep = EXP_KEEP; e.id = id; e.last = 1'b1;
                    exp_q.push_back(e);
                end
            end
        end
        in_act = 1'b0; dg_act = 1'b0; in_hs = 1'b0; dg_hs = 1'b0; cycles = 0;
        while (exp_q.size() > 0 && cycles < 20000) begin
            cyc(); cycles++;
            if (in_hs) begin void'(in_q.pop_front()); in_act = 1'b0; inp_valid = 1'b0; end
            if (dg_hs) begin void'(dg_q.pop_front()); dg_act = 1'b0; digest_valid = 1'b0; end
            if (!in_act && in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                b = in_q[0];
                inp_valid = 1'b1; inp_data = b.data; inp_keep = b.keep; inp_id = b.id; inp_last = b.last;
                in_act = 1'b1;
            end
            if (!dg_act && dg_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                digest_valid = 1'b1; digest_data = dg_q[0]; dg_act = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #2;
            in_hs = inp_valid && inp_ready;
            dg_hs = digest_valid && digest_ready;
            if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                chkw("rnd_data", out_data, e.data);
                chkw("rnd_keep", 512'(out_keep), 512'(e.keep));
                chkw("rnd_id", 512'(out_id), 512'(e.id));
                chk1("rnd_last", out_last, e.last);
            end
        end
        chk1("rnd_drained", exp_q.size() == 0, 1'b1);
        cyc(); inp_valid = 1'b0; digest_valid = 1'b0; #2;
        chkw("rnd_pkt_count", 512'(pkt_count), 512'(1 + NPK));
        chk1("rnd_idle", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
